// File: rtl/aes_round_engine.sv
// Iterative AES encryption engine: one load cycle, then one round per clock
// (NR-1 full rounds plus a final round without MixColumns), then a held result.
module aes_round_engine #(
    parameter int NR      = 10,
    parameter int OUT_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0][3:0][7:0]       state_in,
    input  logic [NR:0][3:0][3:0][7:0] round_keys,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0][3:0][7:0]       state_out,
    output logic                       busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
    typedef logic [3:0][3:0][7:0] blk_t;

    localparam logic [3:0] LAST = 4'(NR);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    fsm_t       state;
    fsm_t       state_nxt;
    logic [3:0] round_cnt;
    blk_t       state_reg;
    blk_t       shifted;
    blk_t       round_out;

    // Multiply by {02} in GF(2^8) with reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes followed by ShiftRows: out[r][c] = S(in[r][(c+r) mod 4]).
    function automatic blk_t sub_shift(input blk_t s);
        blk_t r;
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                r[row][col] = SBOX[s[row][2'(col + row)]];
        return r;
    endfunction

    // MixColumns: each output byte is 02*a[r] ^ 03*a[r+1] ^ a[r+2] ^ a[r+3] within its column.
    function automatic blk_t mix_columns(input blk_t s);
        blk_t r;
        for (int col = 0; col < 4; col++)
            for (int row = 0; row < 4; row++)
                r[row][col] = xtime(s[row][col])
                            ^ xtime(s[2'(row + 1)][col]) ^ s[2'(row + 1)][col]
                            ^ s[2'(row + 2)][col]
                            ^ s[2'(row + 3)][col];
        return r;
    endfunction

    // Round datapath; the last round bypasses MixColumns.
    always_comb begin
        shifted   = sub_shift(state_reg);
        round_out = ((round_cnt == LAST) ? shifted : mix_columns(shifted)) ^ round_keys[round_cnt];
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next-state logic: accept in IDLE, iterate in RUN, hold in DONE until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (round_cnt == LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and round counter: whitening on load, one round per RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= '0;
            round_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= state_in ^ round_keys[0];
                        round_cnt <= 4'd1;
                    end
                end
                RUN: begin
                    state_reg <= round_out;
                    if (round_cnt != LAST) round_cnt <= round_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            blk_t out_q;
            // Holding register captures the final-round result on the RUN->DONE edge.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)                                  out_q <= '0;
                else if (state == RUN && round_cnt == LAST) out_q <= round_out;
            end
            assign state_out = out_q;
        end else begin : g_out_direct
            assign state_out = state_reg;
        end
    endgenerate

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule
